chan_scan_mux: RTL and testbench



---
 rtl/chan_scan_mux.sv | 147 ++++++++++++++
 tb/tb_chan_scan_mux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel, W-bit channel selector with a
// valid/ready output stream.
//
// Manual mode returns the one channel named by sel_in. Scan mode walks the
// channels set in en_mask in ascending order and emits one word per
// handshake. All outputs are registered.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   data_in        N*W packed channel data, channel k at [k*W +: W]
//   mode           0 = manual, 1 = scan (sampled on accepted start)
//   sel_in         manual-mode channel (sampled on accepted start)
//   en_mask        scan-mode channel enables (captured on accepted start)
//   start          begin an operation (accepted only in IDLE)
//   out_valid      out_data/out_ch hold a word
//   out_ready      consumer accepts the word on out_valid & out_ready
//   out_data       selected channel data
//   out_ch         index of the channel in out_data
//   busy           high in EMIT and DONE
//   done           one-cycle pulse at the end of an operation
//
// state | meaning
// IDLE  | waiting for start
// EMIT  | a word is presented on out_data/out_ch, waiting for handshake
// DONE  | single cycle with done=1 before returning to IDLE
module chan_scan_mux #(
  parameter int N = 16,
  parameter int W = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  data_in,
  input  logic            mode,
  input  logic [SELW-1:0] sel_in,
  input  logic [N-1:0]    en_mask,
  input  logic            start,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t          state;
  logic [N-1:0]    mask_q;
  logic            scan_q;

  logic            first_found;
  logic [SELW-1:0] first_idx;
  logic            next_found;
  logic [SELW-1:0] next_idx;
  logic [SELW-1:0] ld_idx;
  logic [W-1:0]    ld_data;

  always_comb begin
    // Descending loops so the last match wins, leaving the lowest index.
    first_found = 1'b0;
    first_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (en_mask[k]) begin
        first_found = 1'b1;
        first_idx   = SELW'(k);
      end
    end

    next_found = 1'b0;
    next_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_q[k] && (k > int'(out_ch))) begin
        next_found = 1'b1;
        next_idx   = SELW'(k);
      end
    end

    if (state == S_IDLE) ld_idx = mode ? first_idx : sel_in;
    else                 ld_idx = next_idx;

    // Indices at or above N match nothing and load zero.
    ld_data = '0;
    for (int k = 0; k < N; k++) begin
      if (ld_idx == SELW'(k)) ld_data = data_in[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mask_q    <= '0;
      scan_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy   <= 1'b1;
            scan_q <= mode;
            if (!mode) begin
              out_data  <= ld_data;
              out_ch    <= sel_in;
              out_valid <= 1'b1;
              state     <= S_EMIT;
            end else begin
              mask_q <= en_mask;
              if (first_found) begin
                out_data  <= ld_data;
                out_ch    <= first_idx;
                out_valid <= 1'b1;
                state     <= S_EMIT;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (scan_q && next_found) begin
              out_data <= ld_data;
              out_ch   <= next_idx;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
module tb_chan_scan_mux;
  localparam int N = 16;
  localparam int W = 4;
  localparam int SELW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N*W-1:0]  data_in;
  logic            mode;
  logic [SELW-1:0] sel_in;
  logic [N-1:0]    en_mask;
  logic            start;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_ch;
  logic            busy;
  logic            done;

  chan_scan_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .sel_in(sel_in),
    .en_mask(en_mask), .start(start), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .busy(busy), .done(done)
  );

  // Second instance: non-power-of-two channel count, wider words.
  logic [39:0] d5_data_in;
  logic        d5_mode;
  logic [2:0]  d5_sel;
  logic [4:0]  d5_mask;
  logic        d5_start;
  logic        d5_valid;
  logic        d5_ready;
  logic [7:0]  d5_data;
  logic [2:0]  d5_ch;
  logic        d5_busy;
  logic        d5_done;

  chan_scan_mux #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst(rst), .data_in(d5_data_in), .mode(d5_mode),
    .sel_in(d5_sel), .en_mask(d5_mask), .start(d5_start),
    .out_valid(d5_valid), .out_ready(d5_ready), .out_data(d5_data),
    .out_ch(d5_ch), .busy(d5_busy), .done(d5_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: a phase plus a queue of channels still to emit.
  int         m_phase = 0;   // 0 idle, 1 emitting, 2 done cycle
  int         m_q[$];
  logic       m_valid = 0, m_busy = 0, m_done = 0;
  int         m_ch = 0;
  logic [W-1:0] m_data = '0;

  function automatic logic [W-1:0] chan_val(input int ch);
    if (ch < N) return data_in[ch*W +: W];
    return '0;
  endfunction

  task automatic load(input int ch);
    m_ch    = ch;
    m_data  = chan_val(ch);
    m_valid = 1'b1;
    m_busy  = 1'b1;
    m_phase = 1;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_phase = 0; m_q.delete();
      m_valid = 0; m_busy = 0; m_done = 0; m_ch = 0; m_data = '0;
    end else begin
      case (m_phase)
        0: begin
          m_done = 0;
          if (start) begin
            m_q.delete();
            if (!mode) load(int'(sel_in));
            else begin
              for (int k = 0; k < N; k++) if (en_mask[k]) m_q.push_back(k);
              if (m_q.size() == 0) begin
                m_phase = 2; m_done = 1; m_busy = 1;
              end else load(m_q.pop_front());
            end
          end
        end
        1: if (out_ready) begin
          if (m_q.size() > 0) load(m_q.pop_front());
          else begin
            m_valid = 0; m_done = 1; m_phase = 2;
          end
        end
        default: begin
          m_done = 0; m_busy = 0; m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("busy",  {31'b0, busy},      {31'b0, m_busy});
    check("done",  {31'b0, done},      {31'b0, m_done});
    if (m_valid) begin
      check("ch",   {28'b0, out_ch},   m_ch);
      check("data", {28'b0, out_data}, {28'b0, m_data});
    end
  endtask

  int exp_seq[4] = '{0, 2, 13, 15};

  initial begin
    rst = 1; start = 0; mode = 0; sel_in = '0; en_mask = '0; out_ready = 1;
    for (int k = 0; k < N; k++) data_in[k*W +: W] = W'(k);
    d5_data_in = 40'h44_33_22_11_00; d5_mode = 0; d5_sel = '0; d5_mask = '0;
    d5_start = 0; d5_ready = 1;
    tick(); tick();
    rst = 0;
    tick();
    check("rst_data", {28'b0, out_data}, 32'h0);
    check("rst_ch",   {28'b0, out_ch},   32'h0);

    // Manual, channel 9.
    sel_in = 4'd9; start = 1; tick(); start = 0;
    check("man_data", {28'b0, out_data}, 32'd9);
    check("man_ch",   {28'b0, out_ch},   32'd9);
    tick();
    check("man_done", {31'b0, done}, 32'd1);
    tick();

    // Scan 0xA005, ready high.
    mode = 1; en_mask = 16'hA005; start = 1; tick(); start = 0;
    en_mask = 16'hFFFF; mode = 0;
    for (int i = 0; i < 4; i++) begin
      check("scan_ch", {28'b0, out_ch}, exp_seq[i]);
      check("scan_v",  {31'b0, out_valid}, 32'd1);
      tick();
    end
    check("scan_done", {31'b0, done}, 32'd1);
    tick();
    check("scan_busy", {31'b0, busy}, 32'd0);

    // Backpressure, mask 0x0003; channel 0 toggles while stalled.
    mode = 1; en_mask = 16'h0003; start = 1; tick(); start = 0;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check("bp_ch",   {28'b0, out_ch},   32'd0);
      check("bp_data", {28'b0, out_data}, 32'd0);
      data_in[3:0] = ~data_in[3:0];
      tick();
    end
    check("bp_ch4",   {28'b0, out_ch},   32'd0);
    check("bp_data4", {28'b0, out_data}, 32'd0);
    out_ready = 1; tick();
    check("bp_ch1",   {28'b0, out_ch},   32'd1);
    check("bp_data1", {28'b0, out_data}, 32'd1);
    tick();
    check("bp_done", {31'b0, done}, 32'd1);
    data_in[3:0] = 4'd0;
    tick();

    // Empty mask.
    en_mask = 16'h0000; start = 1; tick(); start = 0;
    check("empty_v",    {31'b0, out_valid}, 32'd0);
    check("empty_done", {31'b0, done},      32'd1);
    tick();
    check("empty_idle", {31'b0, busy}, 32'd0);

    // Start during EMIT ignored, then reset after channel 2.
    en_mask = 16'hA005; start = 1; tick();
    out_ready = 0; mode = 0; sel_in = 4'd5; tick();
    start = 0;
    check("emit_start_ch", {28'b0, out_ch}, 32'd0);
    out_ready = 1; tick();
    check("mid_ch", {28'b0, out_ch}, 32'd2);
    rst = 1; tick(); rst = 0;
    check("rst_mid", {out_valid, busy, done, out_ch, out_data}, 32'h0);
    tick();
    check("rst_nodone", {31'b0, done}, 32'd0);

    // N=5, W=8: out-of-range and in-range manual selects.
    d5_sel = 3'd6; d5_start = 1; tick(); d5_start = 0;
    check("n5_valid", {31'b0, d5_valid}, 32'd1);
    check("n5_data",  {24'b0, d5_data},  32'h00);
    check("n5_ch",    {29'b0, d5_ch},    32'd6);
    tick();
    check("n5_done", {31'b0, d5_done}, 32'd1);
    tick();
    d5_sel = 3'd3; d5_start = 1; tick(); d5_start = 0;
    check("n5_data3", {24'b0, d5_data}, 32'h33);
    tick(); tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      data_in   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 3) == 0);
      mode      = $urandom_range(0, 1) == 1;
      sel_in    = SELW'($urandom);
      en_mask   = ($urandom_range(0, 1) == 1) ? N'($urandom & $urandom & $urandom) : N'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
